// File: rtl/pcler_counter.sv
// Loadable, clearable up/down counter with programmable terminal value,
// cascade carry chain and a sticky wrap flag.
module pcler_counter #(
    parameter int WIDTH    = 8,
    parameter bit HAS_DOWN = 1'b1
) (
    input  logic             clk_pad,
    input  logic             rst_pad,
    input  logic             load_pad,
    input  logic             clear_pad,
    input  logic             en_pad,
    input  logic             cin_pad,
    input  logic             dir_pad,
    input  logic [WIDTH-1:0] din_pad,
    input  logic [WIDTH-1:0] max_pad,
    output logic [WIDTH-1:0] q_pad,
    output logic             tc_pad,
    output logic             cout_pad,
    output logic             wrap_pad
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             up, count, at_max, at_zero;

    // Without down support the direction input is forced to up.
    assign up      = dir_pad | ~HAS_DOWN;
    assign count   = en_pad & cin_pad;
    assign at_max  = (q_q == max_pad);
    assign at_zero = (q_q == '0);

    assign tc_pad   = up ? at_max : at_zero;
    assign cout_pad = count & tc_pad & ~load_pad & ~clear_pad;
    assign q_pad    = q_q;
    assign wrap_pad = wrap_q;

    // Priority below reset: load, clear, count, hold. A count above max_pad
    // simply rolls over 2^WIDTH without touching the wrap flag.
    always_comb begin
        q_d    = q_q;
        wrap_d = wrap_q;
        if (load_pad) begin
            q_d = din_pad;
        end else if (clear_pad) begin
            q_d    = '0;
            wrap_d = 1'b0;
        end else if (count) begin
            if (up) begin
                if (at_max) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q + ONE;
                end
            end else begin
                if (at_zero) begin
                    q_d    = max_pad;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_pad) begin
        if (rst_pad) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

endmodule

// File: doc/pcler_counter.md
PCLER_COUNTER -- requirements
Module: pcler_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter, load-data and limit width in bits; legal range 2..32.
REQ-002 Parameter HAS_DOWN, default 1: 1 enables down counting; 0 ties the direction internally to up.
REQ-003 clk_pad  input  1: single clock; all state updates on its rising edge.
REQ-004 rst_pad  input  1: reset, synchronous, active-high.
REQ-005 load_pad  input  1: parallel load strobe.
REQ-006 clear_pad  input  1: synchronous clear strobe.
REQ-007 en_pad  input  1: count enable.
REQ-008 cin_pad  input  1: cascade carry-in; counting requires en_pad=1 and cin_pad=1.
REQ-009 dir_pad  input  1: 1 = up, 0 = down; ignored when HAS_DOWN=0.
REQ-010 din_pad  input  WIDTH: parallel load data.
REQ-011 max_pad  input  WIDTH: programmable terminal value (modulus minus 1).
REQ-012 q_pad  output  WIDTH: registered count.
REQ-013 tc_pad  output  1: combinational terminal count; equals (q_pad==max_pad) when up, (q_pad==0) when down.
REQ-014 cout_pad  output  1: combinational cascade carry-out, en_pad & cin_pad & tc_pad & ~load_pad & ~clear_pad.
REQ-015 wrap_pad  output  1: registered sticky wrap flag.

Function
REQ-016 Per-edge priority: rst_pad > load_pad > clear_pad > count > hold.
REQ-017 load_pad=1: q_pad <= din_pad on the next edge; wrap_pad is unchanged.
REQ-018 clear_pad=1 (load_pad=0): q_pad <= 0 and wrap_pad <= 0.
REQ-019 Up count, q_pad==max_pad: q_pad <= 0 and wrap_pad <= 1.
REQ-020 Up count, q_pad!=max_pad: q_pad <= q_pad+1, modulo 2^WIDTH.
REQ-021 Down count, q_pad==0: q_pad <= max_pad and wrap_pad <= 1.
REQ-022 Down count, q_pad!=0: q_pad <= q_pad-1.
REQ-023 en_pad=0 or cin_pad=0 (no load, no clear): q_pad and wrap_pad hold.
REQ-024 q_pad > max_pad (reached by load or by a change to max_pad), up count: q_pad increments modulo 2^WIDTH, passes 2^WIDTH-1 -> 0 with no wrap_pad set and no cout_pad, then follows REQ-019/020.
REQ-025 Latency: exactly one clock from a strobe or enable to the q_pad update.
REQ-026 tc_pad and cout_pad reflect the current q_pad, dir_pad and max_pad with zero latency and carry no internal state.
REQ-027 Cascading: cout_pad of stage n drives cin_pad of stage n+1; the common en_pad gates all stages.
REQ-028 max_pad=0: every up-count edge wraps to 0 and sets wrap_pad; tc_pad holds 1 in both directions while q_pad=0.
REQ-029 dir_pad may change on any cycle; the value sampled at the edge applies.
REQ-030 Simultaneous load_pad and clear_pad: the load wins and wrap_pad is not cleared.

Reset
REQ-031 rst_pad=1 at an edge: q_pad <= 0 and wrap_pad <= 0, overriding every other input.
REQ-032 Reset asserted mid-count takes effect at the next edge; counting resumes on the first edge after deassertion, subject to the enables.
REQ-033 Outputs immediately after reset: q_pad=0; wrap_pad=0; tc_pad=(max_pad==0) if up, 1 if down; cout_pad per REQ-014.

Verification (WIDTH=8, HAS_DOWN=1)
REQ-034 Reset, max=255, en=cin=dir=1 for 256 edges -> q steps 0..255 then 0; cout=1 only while q=255; wrap=1 after the final edge.
REQ-035 load din=0x09, max=0x09, dir=1, one count edge -> q=0x00, wrap=1; the next clear -> q=0, wrap=0.
REQ-036 q=0, max=0x05, dir=0, count -> q=0x05, wrap=1; further counts -> 4,3,2,1,0; tc=1 at q=0.
REQ-037 load=1 and clear=1 together with din=0xA5 -> q=0xA5, wrap unchanged; en=1, cin=0 for 3 edges -> q stays 0xA5.
REQ-038 load din=0xFE, max=0x10, up, 3 edges -> q=0xFF, 0x00, 0x01; wrap stays 0; cout=0 throughout.
REQ-039 Two instances cascaded, both max=255, en=1, low-stage cin=1: at low q=255 the next edge gives low=0 and high increments by 1; assert rst mid-run -> both q=0 on that edge.
